// File: rtl/mul_pcpi_ctrl.sv
// Purpose : PCPI front-end for the M-extension multiplies (MUL/MULH/MULHSU/MULHU).
//           Decodes the instruction, registers the operands for the multiplier and returns the selected result half.
// Latency : ready/wr pulse MUL_LATENCY+1 cycles after the cycle in which the instruction is accepted.
// Backpr. : one instruction at a time; new work is only taken in IDLE. Dropping pcpi_valid during CALC aborts the instruction.
//
// Ports:
//   clk, resetn                    clock, asynchronous active-low reset
//   pcpi_valid/insn/rs1/rs2        co-processor request from the core
//   pcpi_wr/rd/wait/ready          co-processor response to the core
//   mul_rs1/mul_rs2                registered operands to the multiplier
//   mul_operands_sign              operand sign mode for the multiplier
//   mul_res                        full 2*WIDTH product returned by the multiplier

package mul_pcpi_ctrl_pkg;
    typedef enum logic [1:0] {
        RS1_RS2_UNSIGNED = 2'b00,
        RS1_SIGNED       = 2'b01,
        RS1_RS2_SIGNED   = 2'b10
    } op_sign_t;
endpackage

module mul_pcpi_ctrl
    import mul_pcpi_ctrl_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               pcpi_valid,
    input  logic [31:0]        pcpi_insn,
    input  logic [WIDTH-1:0]   pcpi_rs1,
    input  logic [WIDTH-1:0]   pcpi_rs2,
    output logic               pcpi_wr,
    output logic [WIDTH-1:0]   pcpi_rd,
    output logic               pcpi_wait,
    output logic               pcpi_ready,
    output logic [WIDTH-1:0]   mul_rs1,
    output logic [WIDTH-1:0]   mul_rs2,
    output op_sign_t           mul_operands_sign,
    input  logic [2*WIDTH-1:0] mul_res
);

    localparam int CW = (MUL_LATENCY < 1) ? 1 : $clog2(MUL_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      funct3_q;
    logic            insn_match;
    logic            accept;

    // Register-number and rd fields play no part in the decision.
    logic unused_insn_bits;
    assign unused_insn_bits = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

    // bit 14 clear excludes the divide group that shares this opcode/funct7
    assign insn_match = (pcpi_insn[6:0] == 7'b0110011) &&
                        (pcpi_insn[31:25] == 7'b0000001) &&
                        !pcpi_insn[14];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            funct3_q <= 3'b000;
            mul_rs1  <= '0;
            mul_rs2  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                funct3_q <= pcpi_insn[14:12];
                mul_rs1  <= pcpi_rs1;
                mul_rs2  <= pcpi_rs2;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pcpi_valid && insn_match) begin
                    accept  = 1'b1;
                    cnt_d   = CW'(MUL_LATENCY);
                    state_d = CALC;
                end
            end
            CALC: begin
                if (!pcpi_valid) begin
                    // core withdrew the instruction: abandon without a response
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = RESP;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (funct3_q[1:0])
            2'b01:   mul_operands_sign = RS1_RS2_SIGNED;
            2'b10:   mul_operands_sign = RS1_SIGNED;
            default: mul_operands_sign = RS1_RS2_UNSIGNED;
        endcase
    end

    assign pcpi_wait  = (state_q == CALC);
    assign pcpi_ready = (state_q == RESP);
    assign pcpi_wr    = (state_q == RESP);

    always_comb begin
        pcpi_rd = '0;
        if (state_q == RESP) begin
            pcpi_rd = (funct3_q == 3'b000) ? mul_res[WIDTH-1:0] : mul_res[2*WIDTH-1:WIDTH];
        end
    end

endmodule

// File: tb/tb_mul_pcpi_ctrl.sv
module tb_mul_pcpi_ctrl;
    import mul_pcpi_ctrl_pkg::*;

    logic        clk;
    logic        resetn;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;

    // instance 0: MUL_LATENCY=1, instance 1: MUL_LATENCY=3 (same stimulus)
    logic        wr0, wait0, ready0, wr1, wait1, ready1;
    logic [31:0] rd0, mrs1_0, mrs2_0, rd1, mrs1_1, mrs2_1;
    op_sign_t    sign0, sign1;
    logic [63:0] res0, res1, prod0, prod1;
    logic [63:0] pipe1 [3];

    int checks = 0;
    int errors = 0;

    mul_pcpi_ctrl #(.WIDTH(32), .MUL_LATENCY(1)) dut0 (
        .clk(clk), .resetn(resetn), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
        .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(wr0), .pcpi_rd(rd0),
        .pcpi_wait(wait0), .pcpi_ready(ready0), .mul_rs1(mrs1_0), .mul_rs2(mrs2_0),
        .mul_operands_sign(sign0), .mul_res(res0)
    );

    mul_pcpi_ctrl #(.WIDTH(32), .MUL_LATENCY(3)) dut1 (
        .clk(clk), .resetn(resetn), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
        .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(wr1), .pcpi_rd(rd1),
        .pcpi_wait(wait1), .pcpi_ready(ready1), .mul_rs1(mrs1_1), .mul_rs2(mrs2_1),
        .mul_operands_sign(sign1), .mul_res(res1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier models: low 64 bits of the product of the sign-extended operands.
    function automatic logic [63:0] product(input logic [31:0] a, input logic [31:0] b, input op_sign_t s);
        logic [63:0] ea, eb;
        ea = (s != RS1_RS2_UNSIGNED) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (s == RS1_RS2_SIGNED)   ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    assign prod0 = product(mrs1_0, mrs2_0, sign0);
    assign prod1 = product(mrs1_1, mrs2_1, sign1);

    always @(posedge clk) begin
        res0     <= prod0;
        pipe1[0] <= prod1;
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
    end
    assign res1 = pipe1[2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_insn(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    // Issue one instruction to instance 0 at a negedge while in IDLE; check CALC and RESP.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_rd, input op_sign_t exp_sign);
        pcpi_valid = 1'b1;
        pcpi_insn  = mk_insn(7'b0000001, f3);
        pcpi_rs1   = a;
        pcpi_rs2   = b;
        @(negedge clk);
        check({tag, "_calc_wait"},  64'(wait0),  64'd1);
        check({tag, "_calc_ready"}, 64'(ready0), 64'd0);
        check({tag, "_mul_rs1"},    64'(mrs1_0), 64'(a));
        check({tag, "_mul_rs2"},    64'(mrs2_0), 64'(b));
        check({tag, "_sign"},       64'(sign0),  64'(exp_sign));
        @(negedge clk);
        check({tag, "_resp_ready"}, 64'(ready0), 64'd1);
        check({tag, "_resp_wr"},    64'(wr0),    64'd1);
        check({tag, "_resp_wait"},  64'(wait0),  64'd0);
        check({tag, "_rd"},         64'(rd0),    64'(exp_rd));
        pcpi_valid = 1'b0;
        @(negedge clk);
        check({tag, "_idle_ready"}, 64'(ready0), 64'd0);
        check({tag, "_idle_rd"},    64'(rd0),    64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] rv, wv, wrv;
        logic       acc;

        resetn     = 1'b0;
        pcpi_valid = 1'b0;
        pcpi_insn  = '0;
        pcpi_rs1   = '0;
        pcpi_rs2   = '0;
        #12;
        check("rst_wait",  64'(wait0),  64'd0);
        check("rst_ready", 64'(ready0), 64'd0);
        check("rst_wr",    64'(wr0),    64'd0);
        check("rst_rd",    64'(rd0),    64'd0);
        check("rst_rs1",   64'(mrs1_0), 64'd0);
        check("rst_rs2",   64'(mrs2_0), 64'd0);
        check("rst_sign",  64'(sign0),  64'(RS1_RS2_UNSIGNED));
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        run_op("mul",   3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, RS1_RS2_UNSIGNED);
        run_op("mulh",  3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, RS1_RS2_SIGNED);
        run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, RS1_RS2_UNSIGNED);

        // MULHSU then a MUL accepted back-to-back with pcpi_valid held high.
        rv = '0; wv = '0; wrv = '0;
        rv[0] = ready0; wv[0] = wait0; wrv[0] = wr0;
        pcpi_valid = 1'b1;
        pcpi_insn  = mk_insn(7'b0000001, 3'b010);
        pcpi_rs1   = 32'hFFFF_FFFF;
        pcpi_rs2   = 32'hFFFF_FFFF;
        for (int i = 1; i < 7; i++) begin
            @(negedge clk);
            rv[i] = ready0; wv[i] = wait0; wrv[i] = wr0;
            if (i == 1) check("mulhsu_sign", 64'(sign0), 64'(RS1_SIGNED));
            if (i == 2) begin
                check("mulhsu_rd", 64'(rd0), 64'hFFFF_FFFF);
                pcpi_insn = mk_insn(7'b0000001, 3'b000);
                pcpi_rs1  = 32'd3;
                pcpi_rs2  = 32'd5;
            end
            if (i == 5) begin
                check("b2b_mul_rd", 64'(rd0), 64'd15);
                pcpi_valid = 1'b0;
            end
        end
        check("b2b_ready_seq", 64'(rv),  64'(7'b0100100));
        check("b2b_wr_seq",    64'(wrv), 64'(7'b0100100));
        check("b2b_wait_seq",  64'(wv),  64'(7'b0010010));

        // Divide encoding must never be claimed.
        acc = 1'b0;
        pcpi_valid = 1'b1;
        pcpi_insn  = mk_insn(7'b0000001, 3'b100);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            acc = acc | wait0 | ready0 | wr0;
        end
        check("div_silent", 64'(acc), 64'd0);

        // Base-ISA ADD (funct7=0) must never be claimed.
        acc = 1'b0;
        pcpi_insn = mk_insn(7'b0000000, 3'b000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            acc = acc | wait0 | ready0 | wr0;
        end
        check("nonm_silent", 64'(acc), 64'd0);
        pcpi_valid = 1'b0;
        @(negedge clk);

        // Abort: drop pcpi_valid during CALC.
        pcpi_valid = 1'b1;
        pcpi_insn  = mk_insn(7'b0000001, 3'b000);
        pcpi_rs1   = 32'd11;
        pcpi_rs2   = 32'd13;
        @(negedge clk);
        check("abort_calc_wait", 64'(wait0), 64'd1);
        pcpi_valid = 1'b0;
        pcpi_rs1   = 32'd99;
        @(negedge clk);
        check("abort_wait",  64'(wait0),  64'd0);
        check("abort_ready", 64'(ready0), 64'd0);
        check("abort_rs1",   64'(mrs1_0), 64'd11);
        acc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            acc = acc | ready0 | wr0;
        end
        check("abort_no_ready", 64'(acc), 64'd0);

        // Asynchronous reset in the middle of CALC.
        pcpi_valid = 1'b1;
        pcpi_insn  = mk_insn(7'b0000001, 3'b001);
        pcpi_rs1   = 32'h1234_5678;
        pcpi_rs2   = 32'h0000_0010;
        @(negedge clk);
        check("rstmid_calc_wait", 64'(wait0), 64'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("rstmid_wait",  64'(wait0),  64'd0);
        check("rstmid_ready", 64'(ready0), 64'd0);
        check("rstmid_rs1",   64'(mrs1_0), 64'd0);
        check("rstmid_sign",  64'(sign0),  64'(RS1_RS2_UNSIGNED));
        @(negedge clk);
        resetn     = 1'b1;
        pcpi_valid = 1'b0;
        acc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            acc = acc | ready0 | wr0 | wait0;
        end
        check("rstmid_no_ready", 64'(acc), 64'd0);

        // MUL_LATENCY=3 instance: MULHU 0x10000 * 0x10000.
        rv = '0; wv = '0;
        rv[0] = ready1; wv[0] = wait1;
        pcpi_valid = 1'b1;
        pcpi_insn  = mk_insn(7'b0000001, 3'b011);
        pcpi_rs1   = 32'h0001_0000;
        pcpi_rs2   = 32'h0001_0000;
        for (int i = 1; i < 7; i++) begin
            @(negedge clk);
            rv[i] = ready1; wv[i] = wait1;
            if (i == 4) begin
                check("lat3_rd", 64'(rd1), 64'd1);
                check("lat3_wr", 64'(wr1), 64'd1);
                pcpi_valid = 1'b0;
            end
        end
        check("lat3_ready_seq", 64'(rv), 64'(7'b0010000));
        check("lat3_wait_seq",  64'(wv), 64'(7'b0001110));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_pcpi_ctrl.md
Name: mul_pcpi_ctrl

Overview:
PCPI front-end that sits directly upstream of the multiplier datapath and also consumes its result. It decodes MUL/MULH/MULHSU/MULHU from the PicoRV32 co-processor interface, registers the operands and drives them to the multiplier. It selects the operand-sign mode, waits out the multiplier's registered latency, then returns the correct 32-bit half to the core with a single-cycle ready/write pulse.

Parameters:
WIDTH, 32, operand and result width; the multiplier result is 2*WIDTH.
MUL_LATENCY, 1, clock edges from stable multiplier inputs to a valid mul_res; must be 1 or greater.

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
pcpi_valid  input  1  core presents a co-processor instruction
pcpi_insn  input  32  instruction word
pcpi_rs1  input  WIDTH  source operand 1
pcpi_rs2  input  WIDTH  source operand 2
pcpi_wr  output  1  write pcpi_rd to the destination register
pcpi_rd  output  WIDTH  result to core
pcpi_wait  output  1  instruction accepted, result pending
pcpi_ready  output  1  result valid, single-cycle pulse
mul_rs1  output  WIDTH  multiplier operand 1 (registered)
mul_rs2  output  WIDTH  multiplier operand 2 (registered)
mul_operands_sign  output  op_sign_t  sign mode to the multiplier
mul_res  input  2*WIDTH  multiplier result

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on resetn.
  - Reset values: state IDLE, pcpi_wr 0, pcpi_ready 0, pcpi_wait 0, pcpi_rd 0, mul_rs1 0, mul_rs2 0, latency counter 0, funct3 register 0 (MUL, so mul_operands_sign is RS1_RS2_UNSIGNED).
- Decode match (combinational): pcpi_insn[6:0]=7'b0110011, pcpi_insn[31:25]=7'b0000001, pcpi_insn[14]=0.
  - funct3 = pcpi_insn[14:12]: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - funct3 1xx (divide group) is never matched. The block stays silent for it.
- Sign mode, driven from the registered funct3:
  - MULH gives RS1_RS2_SIGNED.
  - MULHSU gives RS1_SIGNED.
  - MUL and MULHU give RS1_RS2_UNSIGNED.
- FSM states IDLE, CALC, RESP.
  - IDLE: when pcpi_valid is high and decode matches, at the edge:
    - capture pcpi_rs1 into mul_rs1, pcpi_rs2 into mul_rs2, funct3 into the funct3 register;
    - load the counter with MUL_LATENCY; set pcpi_wait=1; go to CALC.
    - Otherwise stay in IDLE with all outputs 0.
  - CALC: multiplier inputs are held stable. The counter decrements on each edge.
    - When the counter reaches 0, go to RESP. pcpi_wait stays 1.
  - RESP: lasts exactly one cycle.
    - Outputs: pcpi_ready=1, pcpi_wr=1, pcpi_wait=0.
    - pcpi_rd = mul_res[WIDTH-1:0] for MUL, mul_res[2*WIDTH-1:WIDTH] otherwise.
    - pcpi_rd is driven combinationally from mul_res in RESP and is 0 in all other states.
    - Next state is unconditionally IDLE.
- Latency: with the accept edge at cycle T, pcpi_ready is high during cycle T+MUL_LATENCY+1. For default parameters that is 2 cycles after the accept edge.
- Back-to-back operations: in the cycle after RESP the block is in IDLE and may accept a new instruction if pcpi_valid is high with a match. There is no re-issue of the completed instruction because RESP always exits to IDLE.
- Abort: if pcpi_valid is low during CALC, the next edge goes to IDLE.
  - pcpi_wait goes to 0 and no ready/wr pulse is produced.
  - mul_rs1/mul_rs2 keep their last values.
- pcpi_valid and pcpi_insn are ignored outside IDLE, except for the abort check. Operand changes during CALC have no effect.
- Reset mid-operation: asynchronous return to the reset values in the same instant. No ready pulse is produced for the interrupted instruction.
- pcpi_wr and pcpi_ready are always equal. pcpi_wait and pcpi_ready are never high in the same cycle.

Test Plan:
- MUL, rs1=7, rs2=0xFFFFFFFD -> pcpi_ready/wr pulse exactly 2 cycles after accept, pcpi_rd=0xFFFFFFEB, mul_operands_sign=RS1_RS2_UNSIGNED.
- MULH, rs1=rs2=0x80000000 -> pcpi_rd=0x40000000; MULHU, rs1=rs2=0xFFFFFFFF -> pcpi_rd=0xFFFFFFFE.
- MULHSU, rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> mul_operands_sign=RS1_SIGNED, pcpi_rd=0xFFFFFFFF; then with pcpi_valid held, a second MUL is accepted in the cycle after RESP -> two ready pulses total, each 1 cycle wide.
- DIV encoding (funct3=100) and a non-M opcode (funct7=0000000) with pcpi_valid=1 for 10 cycles -> pcpi_wait, pcpi_ready and pcpi_wr stay 0, state stays IDLE.
- Abort and reset: accept MUL, drop pcpi_valid in CALC -> no ready, IDLE next cycle. Accept MULH, assert resetn=0 mid-CALC -> all outputs 0 immediately, no ready after release.
- MUL_LATENCY=3 build: MULHU 0x00010000*0x00010000 -> pcpi_ready 4 cycles after accept, pcpi_rd=0x00000001, pcpi_wait high for exactly 3 cycles.
